// File: rtl/stream_demux_n_if.sv
// Stream bundle for the 1-to-N demultiplexer: one producer-side stream and N
// consumer-side channels. The demux itself takes the slave view.
interface stream_demux_n_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned SEL_W  = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic [SEL_W-1:0]        in_sel;
    logic                    in_last;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_last;

    modport master (
        output in_valid, in_data, in_sel, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_sel, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with per-channel output registers,
// optional packet-locked routing and a saturating count of dropped beats.
module stream_demux_n #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned N_OUT    = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned LOCK_PKT = 1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    stream_demux_n_if.slave    bus,
    output logic               busy,
    output logic [CNT_W-1:0]   drop_cnt
);
    typedef enum logic [0:0] {StIdle, StRoute} state_e;

    localparam logic [SEL_W:0]   NOutW  = (SEL_W+1)'(N_OUT);
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [SEL_W-1:0]        tgt;
    logic                    drop, tgt_free, xfer;
    logic [N_OUT-1:0]        wr;
    logic [N_OUT-1:0]        out_valid_q, out_last_q;
    logic [N_OUT*DATA_W-1:0] out_data_q;
    logic [CNT_W-1:0]        drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (LOCK_PKT != 0 && xfer) begin
            case (state_q)
                StIdle: begin
                    if (!bus.in_last) begin
                        state_d = StRoute;
                        sel_d   = bus.in_sel;
                    end
                end
                StRoute: begin
                    if (bus.in_last) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // A packet that starts out of range keeps its latched select, so every
    // remaining beat of it is dropped as well.
    always_comb begin
        tgt      = (LOCK_PKT != 0 && state_q == StRoute) ? sel_q : bus.in_sel;
        drop     = {1'b0, tgt} >= NOutW;
        tgt_free = 1'b0;
        for (int i = 0; i < N_OUT; i++) begin
            if (tgt == SEL_W'(i)) tgt_free = ~out_valid_q[i] | bus.out_ready[i];
        end
        bus.in_ready = drop | tgt_free;
        xfer         = bus.in_valid & bus.in_ready;
        for (int i = 0; i < N_OUT; i++) begin
            wr[i] = xfer & ~drop & (tgt == SEL_W'(i));
        end
        busy = (state_q == StRoute);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= '0;
            out_last_q  <= '0;
            out_data_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (wr[i]) begin
                    out_valid_q[i]                <= 1'b1;
                    out_last_q[i]                 <= bus.in_last;
                    out_data_q[i*DATA_W +: DATA_W] <= bus.in_data;
                end else if (bus.out_ready[i]) begin
                    out_valid_q[i] <= 1'b0;
                end
            end
            if (xfer && drop && drop_cnt_q != CntMax) begin
                drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign drop_cnt      = drop_cnt_q;
endmodule

// File: tb/tb_stream_demux_n.sv
// Random-stimulus bench driving two demux configurations with the same input
// stream: A is packet-locked with 3 channels and drops, B routes per beat.
module tb_stream_demux_n;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_demux_n_if #(.DATA_W(8), .N_OUT(3), .SEL_W(2)) if_a ();
    stream_demux_n_if #(.DATA_W(8), .N_OUT(4), .SEL_W(2)) if_b ();

    logic       busy_a, busy_b;
    logic [2:0] drop_a;
    logic [7:0] drop_b;

    stream_demux_n #(
        .DATA_W(8), .N_OUT(3), .SEL_W(2), .LOCK_PKT(1), .CNT_W(3)
    ) u_dut_a (
        .clk      (clk),
        .rst      (rst),
        .bus      (if_a),
        .busy     (busy_a),
        .drop_cnt (drop_a)
    );

    stream_demux_n #(
        .DATA_W(8), .N_OUT(4), .SEL_W(2), .LOCK_PKT(0), .CNT_W(8)
    ) u_dut_b (
        .clk      (clk),
        .rst      (rst),
        .bus      (if_b),
        .busy     (busy_b),
        .drop_cnt (drop_b)
    );

    // Uniform views of both DUTs so one model loop serves both.
    logic [3:0]  ov[2];
    logic [3:0]  ol[2];
    logic [31:0] od[2];
    logic        ir[2];
    logic        bz[2];
    int          dc[2];
    always_comb begin
        ov[0] = {1'b0, if_a.out_valid};
        ov[1] = if_b.out_valid;
        ol[0] = {1'b0, if_a.out_last};
        ol[1] = if_b.out_last;
        od[0] = {8'h00, if_a.out_data};
        od[1] = if_b.out_data;
        ir[0] = if_a.in_ready;
        ir[1] = if_b.in_ready;
        bz[0] = busy_a;
        bz[1] = busy_b;
        dc[0] = int'(drop_a);
        dc[1] = int'(drop_b);
    end

    int errors = 0;
    int checks = 0;
    bit running = 1'b0;
    logic [3:0] cur_ready = '0;

    // Reference model: per-instance packet state, occupancy and expected beats.
    int         nout[2] = '{3, 4};
    bit         lock[2] = '{1'b1, 1'b0};
    int         dmax[2] = '{7, 255};
    bit         route[2];
    int         selq[2];
    int         dcnt[2];
    bit         occ[2][4];
    logic [8:0] q[8][$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s,
                         input logic l, input logic [3:0] r);
        if_a.in_valid  = v;
        if_a.in_data   = d;
        if_a.in_sel    = s;
        if_a.in_last   = l;
        if_a.out_ready = r[2:0];
        if_b.in_valid  = v;
        if_b.in_data   = d;
        if_b.in_sel    = s;
        if_b.in_last   = l;
        if_b.out_ready = r;
        cur_ready      = r;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            route[k] = 1'b0;
            selq[k]  = 0;
            dcnt[k]  = 0;
            for (int ch = 0; ch < 4; ch++) begin
                occ[k][ch] = 1'b0;
                q[k*4+ch].delete();
            end
        end
    endtask

    // Compare the DUT against the model, then advance the model over this edge.
    task automatic step(input bit r_now, input logic v, input logic [7:0] d,
                        input int s, input logic l, input logic [3:0] r);
        for (int k = 0; k < 2; k++) begin
            logic [3:0] exp_ov;
            int  t;
            bit  drp, er;
            bit  wr[4];
            exp_ov = '0;
            for (int ch = 0; ch < 4; ch++) exp_ov[ch] = occ[k][ch];
            check($sformatf("out_valid[%0d]", k), int'(ov[k]), int'(exp_ov));
            check($sformatf("busy[%0d]", k), int'(bz[k]), int'(route[k]));
            check($sformatf("drop_cnt[%0d]", k), dc[k], dcnt[k]);
            t   = (lock[k] && route[k]) ? selq[k] : s;
            drp = t >= nout[k];
            er  = drp || !occ[k][t] || r[t];
            if (!r_now) check($sformatf("in_ready[%0d]", k), int'(ir[k]), int'(er));
            for (int ch = 0; ch < 4; ch++) wr[ch] = 1'b0;
            if (!r_now && v && er) begin
                if (drp) begin
                    if (dcnt[k] < dmax[k]) dcnt[k]++;
                end else begin
                    q[k*4+t].push_back({l, d});
                    wr[t] = 1'b1;
                end
                if (lock[k]) begin
                    if (!route[k]) begin
                        if (!l) begin
                            route[k] = 1'b1;
                            selq[k]  = s;
                        end
                    end else if (l) begin
                        route[k] = 1'b0;
                    end
                end
            end
            for (int ch = 0; ch < nout[k]; ch++) begin
                if (wr[ch]) occ[k][ch] = 1'b1;
                else if (r[ch]) occ[k][ch] = 1'b0;
            end
        end
        if (r_now) model_reset();
    endtask

    // Monitor: pop the expected beat whenever a channel handshake completes.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (running && !rst) begin
                for (int k = 0; k < 2; k++) begin
                    for (int ch = 0; ch < nout[k]; ch++) begin
                        if (ov[k][ch] && cur_ready[ch]) begin
                            if (q[k*4+ch].size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_beat[%0d] ch%0d: got data %0d expected none",
                                         k, ch, od[k][ch*8 +: 8]);
                            end else begin
                                logic [8:0] exp_beat;
                                exp_beat = q[k*4+ch].pop_front();
                                check($sformatf("beat[%0d] ch%0d", k, ch),
                                      int'({ol[k][ch], od[k][ch*8 +: 8]}), int'(exp_beat));
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic       v, l;
        logic [7:0] d;
        int         s;
        logic [3:0] r;
        bit         r_now;
        model_reset();
        drive(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_out_valid[%0d]", k), int'(ov[k]), 0);
            check($sformatf("rst_out_data[%0d]", k), int'(od[k]), 0);
            check($sformatf("rst_out_last[%0d]", k), int'(ol[k]), 0);
            check($sformatf("rst_busy[%0d]", k), int'(bz[k]), 0);
            check($sformatf("rst_drop_cnt[%0d]", k), dc[k], 0);
        end
        running = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r_now = (c > 50) && ($urandom_range(0, 99) == 0);
            rst   = r_now;
            v     = $urandom_range(0, 3) != 0;
            d     = 8'($urandom);
            s     = $urandom_range(0, 3);
            l     = $urandom_range(0, 2) == 0;
            r     = 4'($urandom) | 4'($urandom);
            if ((c % 64) < 16) r[1] = 1'b0;
            drive(v, d, 2'(s), l, r);
            #1;
            step(r_now, v, d, s, l, r);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            rst = 1'b0;
            drive(1'b0, 8'h00, 2'd0, 1'b1, 4'hf);
            #1;
            step(1'b0, 1'b0, 8'h00, 0, 1'b1, 4'hf);
        end
        @(negedge clk);
        #3;
        for (int k = 0; k < 2; k++) begin
            for (int ch = 0; ch < nout[k]; ch++) begin
                check($sformatf("drained[%0d] ch%0d", k, ch), q[k*4+ch].size(), 0);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
